// File: rtl/phase_unwrap_pkg.sv
// Shared CORDIC phase constants (8Q22 bit patterns) and the helper that
// trims them to the fraction width a block actually uses.
package phase_unwrap_pkg;

  localparam int CORDIC_FRAC = 22;

  // pi, 2*pi, 1/(2*pi) in 8Q22; range reduction uses the same patterns
  localparam logic signed [29:0] PI_8Q22      = 30'sd13176795;
  localparam logic signed [29:0] PI2_8Q22     = 30'sd26353589;
  localparam logic signed [29:0] PI2_INV_8Q22 = 30'sd667544;

  // signed net wrap counter
  localparam int WC_W   = 16;
  localparam int WC_MAX = 32767;

  // drop fraction bits below p (truncation, not rounding)
  function automatic logic signed [29:0] trunc_frac(input logic signed [29:0] c, input int p);
    return c >>> (CORDIC_FRAC - p);
  endfunction

endpackage

// File: rtl/phase_unwrap_if.sv
// Stream bus of the phase unwrapper: wrapped phase in, unwrapped phase out,
// plus wrap count and sticky overflow status.
interface phase_unwrap_if
  import phase_unwrap_pkg::*;
#(
  parameter int PD = 8,
  parameter int P  = 22
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic signed [P+3:0]    in_phase;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [PD+P-1:0] out_phase;
  logic signed [WC_W-1:0] wrap_cnt;
  logic                   overflow;

  modport master (
    output in_valid, in_phase, out_ready,
    input  in_ready, out_valid, out_phase, wrap_cnt, overflow
  );

  modport slave (
    input  in_valid, in_phase, out_ready,
    output in_ready, out_valid, out_phase, wrap_cnt, overflow
  );
endinterface

// File: rtl/phase_wrap_detect.sv
// Wrap decision on a phase step: a step beyond +pi means the source wrapped
// downward (remove 2pi), beyond -pi means it wrapped upward (add 2pi).
// Exactly +/-pi is treated as a genuine step.
module phase_wrap_detect #(
  parameter int W = 30
) (
  input  logic signed [W-1:0] delta,
  input  logic signed [W-1:0] pi,
  output logic                dec,
  output logic                inc
);
  assign dec = delta > pi;
  assign inc = delta < -pi;
endmodule

// File: rtl/phase_unwrap.sv
// Phase unwrapper: rebuilds a continuous pdQp phase from wrapped 4Qp samples
// by tracking 2pi wraps. Two stages: stage 1 forms the step vs. the previous
// sample, stage 2 applies the wrap offset and saturates. A single stall
// (output held, not taken) freezes both stages.
module phase_unwrap
  import phase_unwrap_pkg::*;
#(
  parameter int PD = 8,
  parameter int P  = 22
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clear,
  phase_unwrap_if.slave bus
);
  localparam int W  = PD + P;
  // wide enough for WC_MAX * 2pi, so the offset never wraps
  localparam int OW = W + WC_W;

  localparam logic signed [W-1:0]    PI_Q    = W'(trunc_frac(PI_8Q22, P));
  localparam logic signed [W-1:0]    PI2_Q   = W'(trunc_frac(PI2_8Q22, P));
  localparam logic signed [OW-1:0]   PI2_O   = OW'(PI2_Q);
  localparam logic signed [W-1:0]    OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]    OUT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [OW-1:0]   SUM_MAX = {{(OW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [OW-1:0]   SUM_MIN = {{(OW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [WC_W-1:0] WC_LIM  = WC_W'(WC_MAX);
  localparam logic signed [WC_W-1:0] WC_ONE  = WC_W'(1);

  logic                   stall, accept;
  logic signed [W-1:0]    in_ext;

  logic                   s1_valid, s1_first;
  logic signed [W-1:0]    s1_in, s1_delta;
  logic signed [W-1:0]    prev;
  logic                   prev_valid;

  logic                   s2_valid;
  logic signed [W-1:0]    out_q;
  logic signed [OW-1:0]   offset;
  logic signed [WC_W-1:0] wrap_q;
  logic                   ovf_q;

  logic                   wrap_dec, wrap_inc;
  logic signed [OW-1:0]   offset_nx, sum;
  logic signed [WC_W-1:0] wrap_nx;
  logic signed [W-1:0]    sat_phase;
  logic                   sat_hit;

  assign stall        = s2_valid && !bus.out_ready;
  assign accept       = bus.in_valid && !stall;
  assign in_ext       = {{(PD-4){bus.in_phase[P+3]}}, bus.in_phase};

  assign bus.in_ready  = !stall;
  assign bus.out_valid = s2_valid;
  assign bus.out_phase = out_q;
  assign bus.wrap_cnt  = wrap_q;
  assign bus.overflow  = ovf_q;

  // stage 1: capture sample, step vs. previous sample, first-sample flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_first   <= 1'b1;
      s1_in      <= '0;
      s1_delta   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      // a sample taken with clear starts the new sequence
      s1_valid   <= accept;
      s1_first   <= 1'b1;
      prev_valid <= accept;
      if (accept) begin
        s1_in    <= in_ext;
        s1_delta <= '0;
        prev     <= in_ext;
      end
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_in      <= in_ext;
        s1_delta   <= in_ext - prev;
        s1_first   <= !prev_valid;
        prev       <= in_ext;
        prev_valid <= 1'b1;
      end
    end
  end

  logic det_dec, det_inc;

  phase_wrap_detect #(.W(W)) u_detect (
    .delta (s1_delta),
    .pi    (PI_Q),
    .dec   (det_dec),
    .inc   (det_inc)
  );

  assign wrap_dec = det_dec && !s1_first;
  assign wrap_inc = det_inc && !s1_first;

  // stage 2 datapath: offset update (frozen with the counter at its limit), sum, saturation
  always_comb begin
    offset_nx = offset;
    wrap_nx   = wrap_q;
    sat_hit   = 1'b0;
    if (wrap_dec && wrap_q != -WC_LIM) begin
      offset_nx = offset - PI2_O;
      wrap_nx   = wrap_q - WC_ONE;
    end else if (wrap_inc && wrap_q != WC_LIM) begin
      offset_nx = offset + PI2_O;
      wrap_nx   = wrap_q + WC_ONE;
    end
    sum       = {{(OW-W){s1_in[W-1]}}, s1_in} + offset_nx;
    sat_phase = sum[W-1:0];
    if (sum > SUM_MAX) begin
      sat_phase = OUT_MAX;
      sat_hit   = 1'b1;
    end else if (sum < SUM_MIN) begin
      sat_phase = OUT_MIN;
      sat_hit   = 1'b1;
    end
  end

  // stage 2 registers: output, offset accumulator, wrap count, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_q    <= '0;
      offset   <= '0;
      wrap_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      s2_valid <= 1'b0;
      offset   <= '0;
      wrap_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_q  <= sat_phase;
        offset <= offset_nx;
        wrap_q <= wrap_nx;
        ovf_q  <= ovf_q | sat_hit;
      end
    end
  end

endmodule

// File: tb/tb_phase_unwrap.sv
// Bench for phase_unwrap: randomized and directed streams against a
// sample-level unwrap model (running wrap count k, out = in + k*2pi).
module tb_phase_unwrap;
  localparam int  PD     = 8;
  localparam int  P      = 22;
  localparam real PI_R   = 3.141592653589793;
  localparam real SCALE  = 4194304.0;
  localparam longint PI_Q  = 13176795;
  localparam longint PI2_Q = 26353589;
  localparam longint OMAX  = (64'sd1 <<< 29) - 1;
  localparam longint OMIN  = -(64'sd1 <<< 29);
  localparam int  NOXW   = 99999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  phase_unwrap_if #(.PD(PD), .P(P)) bus ();

  phase_unwrap #(.PD(PD), .P(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  typedef struct {
    longint ph;
    int     wc;
    bit     ov;
    int     acc;
    int     xw;
  } exp_t;

  exp_t   q[$];
  longint prev_in;
  bit     pv = 0;
  int     k = 0;
  bit     m_ov = 0;
  int     negcnt = 0;
  int     exp_xw = NOXW;
  bit     lat_mode = 0;
  int     rdy_mode = 0;
  int     since_clr = 0;
  longint last_ph;
  int     last_wc;
  bit     last_ov;

  task automatic model_reset();
    q.delete();
    k    = 0;
    pv   = 0;
    m_ov = 0;
  endtask

  task automatic model_accept(input longint x, input int cnt, input int xw);
    exp_t   e;
    longint s;
    if (pv) begin
      if (x - prev_in > PI_Q) begin
        if (k > -32767) k--;
      end else if (x - prev_in < -PI_Q) begin
        if (k < 32767) k++;
      end
    end
    prev_in = x;
    pv = 1;
    s = x + longint'(k) * PI2_Q;
    if (s > OMAX) begin s = OMAX; m_ov = 1; end
    else if (s < OMIN) begin s = OMIN; m_ov = 1; end
    e.ph = s; e.wc = k; e.ov = m_ov; e.acc = cnt; e.xw = xw;
    q.push_back(e);
  endtask

  function automatic int r2q(input real r);
    if (r >= 0.0) return $rtoi(r * SCALE + 0.5);
    return -$rtoi(-r * SCALE + 0.5);
  endfunction

  function automatic real wrapr(input real x);
    real y = x;
    while (y > PI_R) y = y - 2.0 * PI_R;
    while (y < -PI_R) y = y + 2.0 * PI_R;
    return y;
  endfunction

  // monitor: output checks, hold-while-stalled, then model updates for this edge
  bit     stall_prev = 0;
  longint held_ph = 0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      stall_prev = 0;
    end else begin
      negcnt++;
      chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (stall_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_phase", bus.out_phase, held_ph);
      end
      if (bus.out_valid && bus.out_ready) begin
        since_clr++;
        last_ph = bus.out_phase;
        last_wc = bus.wrap_cnt;
        last_ov = bus.overflow;
        if (q.size() == 0) chk("extra_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_phase", bus.out_phase, e.ph);
          chk("wrap_cnt", bus.wrap_cnt, e.wc);
          chk("overflow", bus.overflow, e.ov);
          if (lat_mode) chk("latency", negcnt - e.acc, 2);
          if (e.xw != NOXW) chk("spec_wrap_cnt", bus.wrap_cnt, e.xw);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_ph    = bus.out_phase;
      if (clear) begin
        model_reset();
        since_clr  = 0;
        stall_prev = 0;
      end
      if (bus.in_valid && bus.in_ready) model_accept(longint'(bus.in_phase), negcnt, exp_xw);
    end
  end

  // downstream ready: 0 = always, 1 = random 50%, 2 = never
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic send(input int x, input bit clr, input int xw);
    int n = 0;
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_phase = x[25:0];
    clear  = clr;
    exp_xw = xw;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        chk("send_timeout", 0, 1);
        acc = 1;
      end
    end
    bus.in_valid = 1'b0;
    clear  = 1'b0;
    exp_xw = NOXW;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real ph;
    bus.in_valid = 1'b0;
    bus.in_phase = '0;

    // reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_phase", bus.out_phase, 0);
    chk("rst_wrap_cnt", bus.wrap_cnt, 0);
    chk("rst_overflow", bus.overflow, 0);
    #20;
    rst_n = 1'b1;
    idle(2);
    chk("rst_in_ready", bus.in_ready, 1);

    // positive wrap, no stall, latency checked
    lat_mode = 1;
    send(r2q(3.0), 0, 0);
    send(r2q(-3.0), 0, 1);
    send(r2q(-2.9), 0, 1);
    idle(4);
    chk("wrap_out_3p38", last_ph, r2q(-2.9) + PI2_Q);

    // async reset mid-stream
    send(r2q(2.0), 0, NOXW);
    send(r2q(-2.0), 0, NOXW);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_wrap_cnt", bus.wrap_cnt, 0);
    chk("async_overflow", bus.overflow, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_in_ready", bus.in_ready, 1);
    send(r2q(-1.0), 0, 0);
    idle(4);
    chk("post_rst_passthru", last_ph, r2q(-1.0));

    // ramp +0.5 rad/sample
    for (int n = 0; n < 100; n++) begin
      ph = 0.5 * n;
      send(r2q(wrapr(ph)), n == 0, $rtoi($floor((ph + PI_R) / (2.0 * PI_R))));
    end
    idle(4);

    // boundary: step of exactly +pi is not a wrap, -2pi is
    send(0, 1, 0);
    send(int'(PI_Q), 0, 0);
    idle(4);
    chk("bnd_pi_out", last_ph, PI_Q);
    send(int'(-PI_Q), 0, 1);
    idle(4);
    chk("bnd_negpi_out", last_ph, PI2_Q - PI_Q);
    lat_mode = 0;

    // backpressure with random walk input
    ph = 0.0;
    send(0, 1, NOXW);
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      ph = wrapr(ph + (real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0) * 2.5);
      send(r2q(ph), 0, NOXW);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rdy_mode = 0;
    idle(6);
    chk("bp_queue_empty", q.size(), 0);

    // descending ramp into overflow, then clear with a new first sample
    for (int n = 0; n < 267; n++) begin
      send(r2q(wrapr(-0.5 * n)), n == 0, NOXW);
    end
    chk("ovf_min_phase", last_ph, OMIN);
    chk("ovf_flag", last_ov, 1);
    send(r2q(1.0), 1, 0);
    idle(6);
    chk("clr_out", last_ph, r2q(1.0));
    chk("clr_wrap_cnt", last_wc, 0);
    chk("clr_overflow", last_ov, 0);
    chk("clr_no_stale", since_clr, 1);
    chk("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
